// File: rtl/pll_md_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pll_md_if                                                   |
// | Brief  : Host request/response channel of the PLL MD controller.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface pll_md_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pll_md_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pll_md_ctrl                                                 |
// | Brief  : Sequences host read/write requests onto the PLL MD bus      |
// |          (address load, data phase, read-back wait) with a cached    |
// |          address pointer so consecutive accesses skip address loads. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module pll_md_ctrl #(
  parameter int MDCLK_DIV = 4,
  parameter bit AINC      = 1'b1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pll_md_if.slave         bus,
  output logic            mdclk,
  output logic [1:0]      mdopc,
  output logic            mdainc,
  output logic [7:0]      mdwdi,
  input  wire logic [7:0] mdrdo
);

  localparam logic [1:0] C_OPC_NOP   = 2'b00;
  localparam logic [1:0] C_OPC_ADDR  = 2'b01;
  localparam logic [1:0] C_OPC_WRITE = 2'b10;
  localparam logic [1:0] C_OPC_READ  = 2'b11;
  localparam logic [8:0] C_LAST      = 9'(2 * MDCLK_DIV - 1);
  localparam logic [8:0] C_HALF      = 9'(MDCLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_RDWAIT = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t     r_state;
  logic [8:0] r_cnt;
  logic [7:0] r_ptr;
  logic       r_ptr_ok;
  logic       r_write;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;

  wire logic       w_last    = (r_cnt == C_LAST);
  wire logic [8:0] w_cnt_inc = r_cnt + 9'd1;

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

  // Controller FSM: phase timer, mdclk generation, MD bus outputs and host handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 9'd0;
      r_ptr       <= 8'h00;
      r_ptr_ok    <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      mdclk       <= 1'b0;
      mdopc       <= C_OPC_NOP;
      mdainc      <= 1'b0;
      mdwdi       <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (bus.req_valid && r_ready) begin
            r_ready <= 1'b0;
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= 9'd0;
            mdclk   <= 1'b0;
            // Address load only when the PLL's internal pointer is unknown or differs.
            if (!r_ptr_ok || (bus.req_addr != r_ptr)) begin
              r_state <= S_ADDR;
              mdopc   <= C_OPC_ADDR;
              mdwdi   <= bus.req_addr;
              mdainc  <= 1'b0;
            end else begin
              r_state <= S_DATA;
              mdopc   <= bus.req_write ? C_OPC_WRITE : C_OPC_READ;
              mdwdi   <= bus.req_write ? bus.req_wdata : 8'h00;
              mdainc  <= AINC;
            end
          end
        end
        S_ADDR: begin
          if (!w_last) begin
            r_cnt <= w_cnt_inc;
            mdclk <= (w_cnt_inc >= C_HALF);
          end else begin
            r_cnt    <= 9'd0;
            mdclk    <= 1'b0;
            r_ptr    <= r_addr;
            r_ptr_ok <= 1'b1;
            r_state  <= S_DATA;
            mdopc    <= r_write ? C_OPC_WRITE : C_OPC_READ;
            mdwdi    <= r_write ? r_wdata : 8'h00;
            mdainc   <= AINC;
          end
        end
        S_DATA: begin
          if (!w_last) begin
            r_cnt <= w_cnt_inc;
            mdclk <= (w_cnt_inc >= C_HALF);
          end else begin
            r_cnt  <= 9'd0;
            mdclk  <= 1'b0;
            mdopc  <= C_OPC_NOP;
            mdwdi  <= 8'h00;
            mdainc <= 1'b0;
            // The PLL auto-increments its pointer; track it so the next access can skip ADDR.
            if (AINC) begin
              r_ptr <= r_ptr + 8'd1;
            end
            if (r_write) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= 8'h00;
            end else begin
              r_state <= S_RDWAIT;
            end
          end
        end
        S_RDWAIT: begin
          if (!w_last) begin
            r_cnt <= w_cnt_inc;
            mdclk <= (w_cnt_inc >= C_HALF);
          end else begin
            r_cnt       <= 9'd0;
            mdclk       <= 1'b0;
            r_rsp_rdata <= mdrdo;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          mdclk   <= 1'b0;
          mdopc   <= C_OPC_NOP;
          mdwdi   <= 8'h00;
          mdainc  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_md_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_pll_md_ctrl                                              |
// | Brief  : Directed self-checking bench for pll_md_ctrl                |
// |          (MDCLK_DIV=2, AINC=1).                                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_pll_md_ctrl;

  localparam int DIV = 2;
  localparam int PH  = 2 * DIV;
  localparam int NTR = 16;

  logic       clk;
  logic       rst;
  logic       mdclk;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;

  int total;
  int bad;

  // Trace of {mdopc, mdwdi, mdainc, mdclk, rsp_valid, req_ready, rsp_rdata}
  // sampled 1 time unit after each posedge, index 0 = the accept edge.
  logic [21:0] t_vec [0:NTR-1];
  logic [21:0] abort_snap;

  pll_md_if bus();

  pll_md_ctrl #(.MDCLK_DIV(DIV), .AINC(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .mdclk  (mdclk),
    .mdopc  (mdopc),
    .mdainc (mdainc),
    .mdwdi  (mdwdi),
    .mdrdo  (mdrdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] obs_now();
    return {mdopc, mdwdi, mdainc, mdclk, bus.rsp_valid, bus.req_ready, bus.rsp_rdata};
  endfunction

  // Reference model of the bus outputs k cycles after the accept edge.
  function automatic logic [21:0] exp_vec(int k, bit has_addr, bit wr,
                                          logic [7:0] a, logic [7:0] d,
                                          logic [7:0] prev_rd, logic [7:0] new_rd);
    int p;
    int q;
    int resp_p;
    logic [1:0] opc;
    logic [7:0] wdi;
    logic       ainc;
    logic       mck;
    logic       rv;
    logic       rdy;
    logic [7:0] rd;
    p = k / PH + (has_addr ? 0 : 1);
    q = k % PH;
    resp_p = wr ? 2 : 3;
    opc = 2'b00; wdi = 8'h00; ainc = 1'b0; mck = 1'b0; rv = 1'b0; rdy = 1'b0; rd = prev_rd;
    if (p < resp_p) mck = (q >= DIV);
    if (p == 0) begin
      opc = 2'b01; wdi = a;
    end else if (p == 1) begin
      opc = wr ? 2'b10 : 2'b11; wdi = wr ? d : 8'h00; ainc = 1'b1;
    end
    if (p == resp_p && q == 0) begin
      rv = 1'b1; rd = new_rd;
    end else if (p >= resp_p) begin
      rdy = 1'b1; rd = new_rd;
    end
    return {opc, wdi, ainc, mck, rv, rdy, rd};
  endfunction

  // Drive one request, record NTR cycles of outputs; optionally pull rst low
  // 2 time units after the sample at cycle abort_k (mid clk-high period).
  task automatic do_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int abort_k);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 50) begin
      bad++;
      $display("FAIL accept_timeout req_ready=%b required=1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    for (int k = 0; k < NTR; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) bus.req_valid = 1'b0;
      t_vec[k] = obs_now();
      if (k == abort_k) begin
        #2 rst = 1'b0;
        #1 abort_snap = obs_now();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs_now() !== 22'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=%h", obs_now(), 22'h0);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs_now() !== 22'h100) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", obs_now(), 22'h100);
    end
    // Reset in the middle of an ADDR phase.
    do_txn(1'b1, 8'h33, 8'h44, 2);
    total++;
    if (abort_snap !== 22'h0) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", abort_snap, 22'h0);
    end
    for (int k = 3; k < NTR; k++) begin
      total++;
      if (t_vec[k] !== 22'h0) begin
        bad++;
        $display("FAIL reset_midstream cyc=%0d got=%h want=%h", k, t_vec[k], 22'h0);
      end
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", bus.req_ready);
    end
  endtask

  task automatic test_cold_write();
    logic [21:0] e;
    do_txn(1'b1, 8'h05, 8'h12, -1);
    for (int k = 0; k < NTR; k++) begin
      total++;
      e = exp_vec(k, 1'b1, 1'b1, 8'h05, 8'h12, 8'h00, 8'h00);
      if (t_vec[k] !== e) begin
        bad++;
        $display("FAIL cold_write cyc=%0d got=%h want=%h", k, t_vec[k], e);
      end
    end
  endtask

  task automatic test_skip_addr();
    logic [21:0] e;
    do_txn(1'b1, 8'h06, 8'h34, -1);
    for (int k = 0; k < NTR; k++) begin
      total++;
      e = exp_vec(k, 1'b0, 1'b1, 8'h06, 8'h34, 8'h00, 8'h00);
      if (t_vec[k] !== e) begin
        bad++;
        $display("FAIL skip_addr cyc=%0d got=%h want=%h", k, t_vec[k], e);
      end
    end
  endtask

  task automatic test_read();
    logic [21:0] e;
    mdrdo = 8'hA5;
    do_txn(1'b0, 8'h06, 8'h00, -1);
    mdrdo = 8'h00;
    for (int k = 0; k < NTR; k++) begin
      total++;
      e = exp_vec(k, 1'b1, 1'b0, 8'h06, 8'h00, 8'h00, 8'hA5);
      if (t_vec[k] !== e) begin
        bad++;
        $display("FAIL read cyc=%0d got=%h want=%h", k, t_vec[k], e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [21:0] e;
    do_txn(1'b1, 8'hFF, 8'h77, -1);
    for (int k = 0; k < NTR; k++) begin
      total++;
      e = exp_vec(k, 1'b1, 1'b1, 8'hFF, 8'h77, 8'hA5, 8'h00);
      if (t_vec[k] !== e) begin
        bad++;
        $display("FAIL wrap_first cyc=%0d got=%h want=%h", k, t_vec[k], e);
      end
    end
    do_txn(1'b1, 8'h00, 8'h88, -1);
    for (int k = 0; k < NTR; k++) begin
      total++;
      e = exp_vec(k, 1'b0, 1'b1, 8'h00, 8'h88, 8'h00, 8'h00);
      if (t_vec[k] !== e) begin
        bad++;
        $display("FAIL wrap_second cyc=%0d got=%h want=%h", k, t_vec[k], e);
      end
    end
  endtask

  task automatic test_abort();
    logic [21:0] e;
    // Cycle 6 is the first mdclk-high cycle of DATA after a 4-cycle ADDR.
    do_txn(1'b1, 8'h40, 8'h55, 6);
    for (int k = 0; k < NTR; k++) begin
      total++;
      e = (k <= 6) ? exp_vec(k, 1'b1, 1'b1, 8'h40, 8'h55, 8'h00, 8'h00) : 22'h0;
      if (t_vec[k] !== e) begin
        bad++;
        $display("FAIL abort cyc=%0d got=%h want=%h", k, t_vec[k], e);
      end
    end
    @(negedge clk) rst = 1'b1;
    do_txn(1'b1, 8'h40, 8'h66, -1);
    for (int k = 0; k < NTR; k++) begin
      total++;
      e = exp_vec(k, 1'b1, 1'b1, 8'h40, 8'h66, 8'h00, 8'h00);
      if (t_vec[k] !== e) begin
        bad++;
        $display("FAIL abort_readdr cyc=%0d got=%h want=%h", k, t_vec[k], e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    mdrdo = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    abort_snap    = 22'h0;
    test_reset();
    test_cold_write();
    test_skip_addr();
    test_read();
    test_wrap();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
